// File: rtl/vram_write_sched_pkg.sv
// rtl/vram_write_sched_pkg.sv - shared VRAM geometry and fill FSM encoding
// Purpose: constants shared with CHR_GEN / NTSC_TG and the fill FSM state type.
// Ports: none (package).
package vram_write_sched_pkg;

  localparam int C_VRAM_AW = 10;
  localparam int C_VRAM_DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

endpackage

// File: rtl/vram_write_sched_if.sv
// rtl/vram_write_sched_if.sv - CPU write bus and VRAM write port bundle
// Purpose: groups the CPU write handshake and the VRAM write port signals.
// Signals:
//   CPU_WDs/CPU_WAs/CPU_WE  CPU write data/address/valid (master -> slave)
//   CPU_RDY                 FIFO can accept (slave -> master)
//   VRAM_WDs/WAs/WE         write port towards CHR_GEN (slave -> master)
interface vram_write_sched_if
  import vram_write_sched_pkg::*;
#(
  parameter int C_AW = C_VRAM_AW,
  parameter int C_DW = C_VRAM_DW
);

  logic [C_DW-1:0] CPU_WDs;
  logic [C_AW-1:0] CPU_WAs;
  logic            CPU_WE;
  logic            CPU_RDY;
  logic [C_DW-1:0] VRAM_WDs;
  logic [C_AW-1:0] VRAM_WAs;
  logic            VRAM_WE;

  modport master (
    output CPU_WDs, CPU_WAs, CPU_WE,
    input  CPU_RDY, VRAM_WDs, VRAM_WAs, VRAM_WE
  );

  modport slave (
    input  CPU_WDs, CPU_WAs, CPU_WE,
    output CPU_RDY, VRAM_WDs, VRAM_WAs, VRAM_WE
  );

endinterface

// File: rtl/vram_wr_fifo.sv
// rtl/vram_wr_fifo.sv - synchronous first-word-fall-through FIFO
// Purpose: small CPU write buffer; head word is always visible on rdata_o.
// Ports:
//   clk_i, rstn_i        clock, synchronous active-low reset
//   push_i, wdata_i      write request/data (refused while full)
//   pop_i                drop head word (ignored while empty)
//   rdata_o              head word
//   full_o, empty_o      status from the registered count
//   count_o              number of stored words
module vram_wr_fifo #(
  parameter int C_W    = 18,
  parameter int C_FD_W = 2
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              push_i,
  input  logic [C_W-1:0]    wdata_i,
  input  logic              pop_i,
  output logic [C_W-1:0]    rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [C_FD_W:0]   count_o
);

  localparam int LP_DEPTH = 1 << C_FD_W;
  localparam logic [C_FD_W:0] LP_FULL = (C_FD_W+1)'(LP_DEPTH);

  logic [C_W-1:0]    mem_q [LP_DEPTH];
  logic [C_FD_W-1:0] wptr_q, rptr_q;
  logic [C_FD_W:0]   cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign full_o  = (cnt_q == LP_FULL);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  // Full refuses a push even when a pop frees a slot in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/vram_write_sched.sv
// rtl/vram_write_sched.sv - VRAM write port scheduler (CPU FIFO + fill engine)
// Purpose: shares the single CHR_GEN VRAM write port between buffered CPU
//   writes and a range-fill engine; at most one write per CK_EE_i slot,
//   optionally only during blanking.
// Ports:
//   CK_i, XSYS_R_i        clock, synchronous active-low reset
//   CK_EE_i               write-slot clock enable
//   BLANK_i               blanking indicator
//   BUS_WR_BLANK_ONLY     restrict writes to blanking
//   FILL_REQ_i            start fill (sampled while idle)
//   FILL_CODEs_i          fill code
//   FILL_STARTs_i         first fill address
//   FILL_LENs_i           fill length, 0 means the whole VRAM
//   FILL_BUSY_o           fill engine active
//   FILL_DONE_o           one-cycle pulse at fill completion
//   bus                   CPU write handshake and VRAM write port
module vram_write_sched
  import vram_write_sched_pkg::*;
#(
  parameter int C_AW   = C_VRAM_AW,
  parameter int C_DW   = C_VRAM_DW,
  parameter int C_FD_W = 2
) (
  input  logic                CK_i,
  input  logic                XSYS_R_i,
  input  logic                CK_EE_i,
  input  logic                BLANK_i,
  input  logic                BUS_WR_BLANK_ONLY,
  input  logic                FILL_REQ_i,
  input  logic [C_DW-1:0]     FILL_CODEs_i,
  input  logic [C_AW-1:0]     FILL_STARTs_i,
  input  logic [C_AW-1:0]     FILL_LENs_i,
  output logic                FILL_BUSY_o,
  output logic                FILL_DONE_o,
  vram_write_sched_if.slave   bus
);

  logic [C_AW+C_DW-1:0] fifo_rdata;
  logic                 fifo_full, fifo_empty;
  logic [C_FD_W:0]      fifo_count_unused;

  fill_state_e          state_q, state_d;
  logic [C_AW-1:0]      adr_q, adr_d;
  logic [C_AW:0]        rem_q, rem_d;
  logic [C_DW-1:0]      code_q, code_d;

  logic                 last_fill_q;
  logic [C_DW-1:0]      vram_wd_q;
  logic [C_AW-1:0]      vram_wa_q;
  logic                 vram_we_q;

  logic                 slot, cpu_cand, fill_cand, gnt_cpu, gnt_fill;

  vram_wr_fifo #(
    .C_W    (C_AW + C_DW),
    .C_FD_W (C_FD_W)
  ) u_fifo (
    .clk_i   (CK_i),
    .rstn_i  (XSYS_R_i),
    .push_i  (bus.CPU_WE),
    .wdata_i ({bus.CPU_WAs, bus.CPU_WDs}),
    .pop_i   (gnt_cpu),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_unused)
  );

  assign slot      = CK_EE_i & (~BUS_WR_BLANK_ONLY | BLANK_i);
  assign cpu_cand  = ~fifo_empty;
  assign fill_cand = (state_q == ST_RUN);

  // Round-robin: on a tie the previous winner yields.
  always_comb begin
    gnt_cpu  = 1'b0;
    gnt_fill = 1'b0;
    if (slot) begin
      if (cpu_cand && fill_cand) begin
        if (last_fill_q) gnt_cpu  = 1'b1;
        else             gnt_fill = 1'b1;
      end else begin
        gnt_cpu  = cpu_cand;
        gnt_fill = fill_cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    rem_d   = rem_q;
    code_d  = code_q;
    case (state_q)
      ST_IDLE: begin
        if (FILL_REQ_i) begin
          code_d  = FILL_CODEs_i;
          adr_d   = FILL_STARTs_i;
          rem_d   = (FILL_LENs_i == '0) ? {1'b1, {C_AW{1'b0}}} : {1'b0, FILL_LENs_i};
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (gnt_fill) begin
          adr_d = adr_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == (C_AW+1)'(1)) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CK_i) begin
    if (!XSYS_R_i) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      rem_q   <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      rem_q   <= rem_d;
      code_q  <= code_d;
    end
  end

  // Outputs only move on CK_EE_i so each write lasts one full CK_EE period.
  always_ff @(posedge CK_i) begin
    if (!XSYS_R_i) begin
      vram_wd_q   <= '0;
      vram_wa_q   <= '0;
      vram_we_q   <= 1'b0;
      last_fill_q <= 1'b0;
    end else begin
      if (gnt_cpu || gnt_fill) last_fill_q <= gnt_fill;
      if (CK_EE_i) begin
        vram_we_q <= gnt_cpu | gnt_fill;
        if (gnt_cpu) begin
          vram_wa_q <= fifo_rdata[C_AW+C_DW-1:C_DW];
          vram_wd_q <= fifo_rdata[C_DW-1:0];
        end else if (gnt_fill) begin
          vram_wa_q <= adr_q;
          vram_wd_q <= code_q;
        end
      end
    end
  end

  assign bus.CPU_RDY  = ~fifo_full;
  assign bus.VRAM_WDs = vram_wd_q;
  assign bus.VRAM_WAs = vram_wa_q;
  assign bus.VRAM_WE  = vram_we_q;
  assign FILL_BUSY_o  = (state_q != ST_IDLE);
  assign FILL_DONE_o  = (state_q == ST_DONE);

endmodule
